// File: rtl/lcd_text_arbiter.sv
// Two-source arbiter for the 32-character LCD text frame. The granted source
// edits a shadow copy that is committed atomically, then held for a dwell time.
module lcd_text_arbiter #(
  parameter int unsigned DWELL   = 50000000,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  output logic         gnt0,
  output logic         gnt1,
  input  logic         wr_en0,
  input  logic         wr_en1,
  input  logic [4:0]   wr_addr0,
  input  logic [4:0]   wr_addr1,
  input  logic [7:0]   wr_char0,
  input  logic [7:0]   wr_char1,
  input  logic         done0,
  input  logic         done1,
  output logic [255:0] frame,
  output logic         frame_update,
  output logic         owner,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT, HOLD} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             src_q, src_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             update_q, update_d;
  logic             load_shadow;
  logic             commit;

  logic [7:0] frame_q  [32];
  logic [7:0] shadow_q [32];

  // Only the granted source's strobes ever reach the shadow buffer.
  logic       req_sel, wr_en_sel, done_sel;
  logic [4:0] wr_addr_sel;
  logic [7:0] wr_char_sel;

  assign req_sel     = src_q ? req1     : req0;
  assign wr_en_sel   = src_q ? wr_en1   : wr_en0;
  assign done_sel    = src_q ? done1    : done0;
  assign wr_addr_sel = src_q ? wr_addr1 : wr_addr0;
  assign wr_char_sel = src_q ? wr_char1 : wr_char0;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      update_q  <= update_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    update_d    = 1'b0;
    load_shadow = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = GRANT;
          src_d       = (req0 && req1) ? prio_q : !req0;
          load_shadow = 1'b1;
          cnt_d       = '0;
        end
      end
      GRANT: begin
        // prio_q names the source favoured on the next tie: the one not just served.
        if (done_sel) begin
          state_d = COMMIT;
          prio_d  = !src_q;
        end else if (!req_sel) begin
          state_d = IDLE;
          prio_d  = !src_q;
        end else if (wr_en_sel) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          prio_d    = !src_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        commit   = 1'b1;
        owner_d  = src_q;
        state_d  = HOLD;
        cnt_d    = '0;
        update_d = 1'b1;
      end
      HOLD: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        frame_q[i]  <= 8'h20;
        shadow_q[i] <= 8'h20;
      end
    end else begin
      if (load_shadow) begin
        shadow_q <= frame_q;
      end else if (state_q == GRANT && wr_en_sel) begin
        shadow_q[wr_addr_sel] <= wr_char_sel;
      end
      if (commit) begin
        frame_q <= shadow_q;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_frame
      assign frame[8*gi +: 8] = frame_q[gi];
    end
  endgenerate

  assign gnt0         = (state_q == GRANT) && !src_q;
  assign gnt1         = (state_q == GRANT) && src_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
  assign frame_update = update_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed bench for lcd_text_arbiter with DWELL=8, TIMEOUT=16; expected
// frames are built by hand from a blank frame plus the characters written.
module tb_lcd_text_arbiter;

  logic         Clk;
  logic         reset;
  logic         req0, req1;
  logic         gnt0, gnt1;
  logic         wr_en0, wr_en1;
  logic [4:0]   wr_addr0, wr_addr1;
  logic [7:0]   wr_char0, wr_char1;
  logic         done0, done1;
  logic [255:0] frame;
  logic         frame_update;
  logic         owner;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  logic [255:0] spaces;
  logic [255:0] exp_frame;

  lcd_text_arbiter #(.DWELL(8), .TIMEOUT(16), .CNT_W(32)) dut (
    .Clk(Clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_char0(wr_char0), .wr_char1(wr_char1),
    .done0(done0), .done1(done1),
    .frame(frame), .frame_update(frame_update), .owner(owner),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    spaces = {32{8'h20}};
    reset = 1'b0;
    req0 = 0; req1 = 0; wr_en0 = 0; wr_en1 = 0; done0 = 0; done1 = 0;
    wr_addr0 = '0; wr_addr1 = '0; wr_char0 = '0; wr_char1 = '0;
    steps(2);
    reset = 1'b1;
    check("rst_frame", frame, spaces);
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 1'b0);
    check("rst_update", frame_update, 1'b0);

    // Single source writes "HI"
    req0 = 1; step();
    check("single_gnt0", {gnt1, gnt0}, 2'b01);
    wr_en0 = 1; wr_addr0 = 5'd0; wr_char0 = 8'h48; step();
    wr_addr0 = 5'd1; wr_char0 = 8'h49; step();
    wr_en0 = 0; done0 = 1; step();
    done0 = 0; req0 = 0;
    check("commit_gnt_drop", {gnt1, gnt0}, 2'b00);
    check("commit_frame_old", frame, spaces);
    step();
    exp_frame = spaces; exp_frame[7:0] = 8'h48; exp_frame[15:8] = 8'h49;
    check("single_frame", frame, exp_frame);
    check("single_update", frame_update, 1'b1);
    check("single_owner", owner, 1'b0);
    step();
    check("single_update_pulse", frame_update, 1'b0);
    steps(6);
    check("hold_busy_last", busy, 1'b1);
    step();
    check("hold_busy_end", busy, 1'b0);

    // Abort mid-message
    req0 = 1; step();
    check("abort_gnt0", gnt0, 1'b1);
    wr_en0 = 1; wr_addr0 = 5'd2; wr_char0 = 8'h5A; step();
    wr_en0 = 0; req0 = 0; step();
    check("abort_gnt", {gnt1, gnt0}, 2'b00);
    check("abort_busy", busy, 1'b0);
    step();
    check("abort_frame", frame, exp_frame);

    // Timeout on source 1
    req1 = 1; step();
    check("to_gnt1", {gnt1, gnt0}, 2'b10);
    wr_en1 = 1; wr_addr1 = 5'd5; wr_char1 = 8'h58; step();
    wr_en1 = 0;
    steps(15);
    check("to_not_yet", {timeout_err, gnt1}, 2'b01);
    step();
    req1 = 0;
    check("to_err", timeout_err, 1'b1);
    check("to_gnt_drop", gnt1, 1'b0);
    check("to_busy", busy, 1'b0);
    check("to_frame", frame, exp_frame);
    step();
    check("to_err_pulse", timeout_err, 1'b0);
    check("to_no_dwell", busy, 1'b0);

    // Commit from source 1 (write with done), then reset during HOLD
    req1 = 1; step();
    check("s1_gnt1", gnt1, 1'b1);
    wr_en1 = 1; wr_addr1 = 5'd31; wr_char1 = 8'h51; done1 = 1; step();
    wr_en1 = 0; done1 = 0; req1 = 0; step();
    exp_frame[255:248] = 8'h51;
    check("s1_frame", frame, exp_frame);
    check("s1_owner", owner, 1'b1);
    step();
    reset = 0; step();
    check("hold_rst_frame", frame, spaces);
    check("hold_rst_gnt", {gnt1, gnt0}, 2'b00);
    check("hold_rst_busy", busy, 1'b0);
    check("hold_rst_owner", owner, 1'b0);
    reset = 1;

    // Contention, isolation and alternation
    req0 = 1; req1 = 1; step();
    check("cont_gnt0", {gnt1, gnt0}, 2'b01);
    wr_en1 = 1; wr_addr1 = 5'd16; wr_char1 = 8'h41; done1 = 1; step();
    wr_en1 = 0; done1 = 0;
    check("iso_gnt", {gnt1, gnt0}, 2'b01);
    step();
    check("iso_frame", frame, spaces);
    check("iso_no_update", frame_update, 1'b0);
    wr_en0 = 1; wr_addr0 = 5'd16; wr_char0 = 8'h30; done0 = 1; step();
    wr_en0 = 0; done0 = 0; step();
    exp_frame = spaces; exp_frame[135:128] = 8'h30;
    check("cont_s0_frame", frame, exp_frame);
    check("cont_s0_owner", owner, 1'b0);
    steps(8);
    check("cont_idle", {busy, gnt1, gnt0}, 3'b000);
    step();
    check("cont_gnt1", {gnt1, gnt0}, 2'b10);
    wr_en1 = 1; wr_addr1 = 5'd17; wr_char1 = 8'h42; done1 = 1; step();
    wr_en1 = 0; done1 = 0; step();
    exp_frame[143:136] = 8'h42;
    check("cont_s1_frame", frame, exp_frame);
    check("cont_s1_owner", owner, 1'b1);
    steps(9);
    check("cont_gnt0_again", {gnt1, gnt0}, 2'b01);
    req0 = 0; req1 = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
